aes_out_serializer: RTL and testbench

Downstream of `AES_top`, this block captures each 128-bit result block when `AES_data_out_valid` rises. It buffers up to `DEPTH` blocks and streams each block out as four 32-bit words over a valid/ready handshake. This decouples the cipher core from a narrow, possibly stalling consumer such as a bus bridge or UART packer. It reports overflow when the consumer cannot keep up.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_out_serializer_if.sv | 13 +
 rtl/aes_blk_fifo.sv | 63 ++++++
 rtl/aes_out_serializer.sv | 79 +++++++
 tb/tb_aes_out_serializer.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared constants, types and helpers for the AES output serializer slice.
package aes_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_WORD_W = 32;
    localparam int AES_WORDS  = 4;

    typedef logic [1:0] widx_t;

    localparam widx_t LAST_WIDX = widx_t'(AES_WORDS - 1);

    // Word 0 is the most significant 32 bits of the block.
    function automatic logic [AES_WORD_W-1:0] select_word(input logic [AES_BLK_W-1:0] blk,
                                                          input widx_t idx);
        case (idx)
            2'd0:    return blk[127:96];
            2'd1:    return blk[95:64];
            2'd2:    return blk[63:32];
            default: return blk[31:0];
        endcase
    endfunction

endpackage

// File: rtl/aes_out_serializer_if.sv
// Word stream from the serializer to a narrow consumer (valid/ready handshake).
interface aes_out_serializer_if;
    import aes_pkg::*;

    logic [AES_WORD_W-1:0] ser_data;
    logic                  ser_valid;
    logic                  ser_ready;
    logic                  ser_last;

    modport master (output ser_data, ser_valid, ser_last, input ser_ready);
    modport slave  (input ser_data, ser_valid, ser_last, output ser_ready);

endinterface

// File: rtl/aes_blk_fifo.sv
// DEPTH-entry FIFO of 128-bit blocks; a push into a full FIFO is allowed when
// the head is popped in the same cycle.
module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [AES_BLK_W-1:0]      push_data,
    input  logic                      pop,
    output logic [AES_BLK_W-1:0]      head_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    logic [AES_BLK_W-1:0] mem [DEPTH];
    ptr_t                 wr_ptr;
    ptr_t                 rd_ptr;
    ptr_t                 level_q;
    logic                 push_ok;
    logic                 pop_ok;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && (level_q != '0);
    assign push_ok = push && (!full || pop_ok);

    assign head_data = mem[rd_ptr[AW-1:0]];
    assign level     = level_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + ptr_t'(1);
                2'b01:   level_q <= level_q - ptr_t'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/aes_out_serializer.sv
// Captures AES result blocks on the rising edge of their valid and streams
// each block out as four 32-bit words, MS word first, with sticky overflow.
module aes_out_serializer
    import aes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      AES_clk,
    input  logic                      AES_rst_n,
    input  logic [AES_BLK_W-1:0]      AES_data_out,
    input  logic                      AES_data_out_valid,
    aes_out_serializer_if.master      ser,
    output logic [$clog2(DEPTH):0]    blk_level,
    output logic                      ovf,
    input  logic                      ovf_clr
);

    logic                 vld_q;
    logic                 capture;
    logic                 handshake;
    logic                 last_pop;
    logic                 push;
    logic                 drop;
    logic                 full;
    logic [AES_BLK_W-1:0] head_data;
    widx_t                widx;

    assign capture   = AES_data_out_valid && !vld_q;
    assign handshake = ser.ser_valid && ser.ser_ready;
    assign last_pop  = handshake && (widx == LAST_WIDX);
    assign push      = capture && (!full || last_pop);
    assign drop      = capture && full && !last_pop;

    aes_blk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (AES_clk),
        .rst_n     (AES_rst_n),
        .push      (push),
        .push_data (AES_data_out),
        .pop       (last_pop),
        .head_data (head_data),
        .level     (blk_level),
        .full      (full)
    );

    // Outputs depend only on registered state, never on ser_ready or the AES inputs.
    always_comb begin
        ser.ser_valid = (blk_level != '0);
        ser.ser_data  = '0;
        ser.ser_last  = 1'b0;
        if (ser.ser_valid) begin
            ser.ser_data = select_word(head_data, widx);
            ser.ser_last = (widx == LAST_WIDX);
        end
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            vld_q <= 1'b0;
            widx  <= '0;
            ovf   <= 1'b0;
        end else begin
            vld_q <= AES_data_out_valid;
            if (last_pop) begin
                widx <= '0;
            end else if (handshake) begin
                widx <= widx + widx_t'(1);
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed self-checking bench for aes_out_serializer with DEPTH = 2.
module tb_aes_out_serializer;

    logic         clk;
    logic         rst_n;
    logic [127:0] aes_data;
    logic         aes_valid;
    logic [1:0]   blk_level;
    logic         ovf;
    logic         ovf_clr;
    int           checks;
    int           errors;

    localparam logic [127:0] BLK_D = 128'h3925841d_02dc09fb_dc118597_196a0b32;
    localparam logic [127:0] BLK_E = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] BLK_A = 128'haaaa0000_aaaa1111_aaaa2222_aaaa3333;
    localparam logic [127:0] BLK_B = 128'hbbbb0000_bbbb1111_bbbb2222_bbbb3333;
    localparam logic [127:0] BLK_C = 128'hcccc0000_cccc1111_cccc2222_cccc3333;

    aes_out_serializer_if ser_bus ();

    aes_out_serializer #(
        .DEPTH (2)
    ) dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .AES_data_out       (aes_data),
        .AES_data_out_valid (aes_valid),
        .ser                (ser_bus),
        .blk_level          (blk_level),
        .ovf                (ovf),
        .ovf_clr            (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input logic [127:0] blk, input int k);
        logic [127:0] t;
        t = blk >> (32 * (3 - k));
        return t[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle capture pulse followed by a low cycle so the next pulse is a fresh edge.
    task automatic send_block(input logic [127:0] blk);
        aes_data  = blk;
        aes_valid = 1'b1;
        tick();
        aes_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (ser_bus.ser_valid !== 1'b0 || ser_bus.ser_data !== 32'h0 || ser_bus.ser_last !== 1'b0
            || blk_level !== 2'd0 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset: valid=%b data=%h last=%b level=%0d ovf=%b, need all 0",
                     ser_bus.ser_valid, ser_bus.ser_data, ser_bus.ser_last, blk_level, ovf);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_block();
        ser_bus.ser_ready = 1'b1;
        aes_data  = BLK_D;
        aes_valid = 1'b1;
        tick();
        aes_valid = 1'b0;
        checks++;
        if (blk_level !== 2'd1) begin
            errors++;
            $display("[TB] FAIL single_level: got %0d need 1", blk_level);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ser_bus.ser_valid !== 1'b1 || ser_bus.ser_data !== exp_word(BLK_D, k)
                || ser_bus.ser_last !== (k == 3)) begin
                errors++;
                $display("[TB] FAIL single_word%0d: valid=%b data=%h last=%b need 1 %h %b", k,
                         ser_bus.ser_valid, ser_bus.ser_data, ser_bus.ser_last,
                         exp_word(BLK_D, k), (k == 3));
            end
            tick();
        end
        checks++;
        if (blk_level !== 2'd0 || ser_bus.ser_valid !== 1'b0 || ser_bus.ser_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL single_drain: level=%0d valid=%b data=%h need 0 0 0",
                     blk_level, ser_bus.ser_valid, ser_bus.ser_data);
        end
    endtask

    task automatic test_level_valid();
        int words;
        int lasts;
        words = 0;
        lasts = 0;
        ser_bus.ser_ready = 1'b1;
        aes_data  = BLK_E;
        aes_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 9) aes_valid = 1'b0;
            if (ser_bus.ser_valid) begin
                checks++;
                if (ser_bus.ser_data !== exp_word(BLK_E, words % 4)) begin
                    errors++;
                    $display("[TB] FAIL level_word%0d: got %h need %h", words,
                             ser_bus.ser_data, exp_word(BLK_E, words % 4));
                end
                if (ser_bus.ser_last) lasts++;
                words++;
            end
        end
        checks++;
        if (words != 4 || lasts != 1) begin
            errors++;
            $display("[TB] FAIL level_count: words=%0d lasts=%0d need 4 1", words, lasts);
        end
    endtask

    task automatic test_stall();
        ser_bus.ser_ready = 1'b1;
        aes_data  = BLK_D;
        aes_valid = 1'b1;
        tick();
        aes_valid = 1'b0;
        tick();
        ser_bus.ser_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ser_bus.ser_data !== 32'h02dc09fb || ser_bus.ser_last !== 1'b0
                || ser_bus.ser_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: data=%h last=%b valid=%b need 02dc09fb 0 1",
                         i, ser_bus.ser_data, ser_bus.ser_last, ser_bus.ser_valid);
            end
        end
        ser_bus.ser_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (ser_bus.ser_data !== exp_word(BLK_D, k) || ser_bus.ser_last !== (k == 3)) begin
                errors++;
                $display("[TB] FAIL stall_resume%0d: data=%h last=%b need %h %b", k,
                         ser_bus.ser_data, ser_bus.ser_last, exp_word(BLK_D, k), (k == 3));
            end
            tick();
        end
        checks++;
        if (ser_bus.ser_valid !== 1'b0 || blk_level !== 2'd0) begin
            errors++;
            $display("[TB] FAIL stall_drain: valid=%b level=%0d need 0 0",
                     ser_bus.ser_valid, blk_level);
        end
    endtask

    task automatic test_overflow();
        logic [127:0] blk;
        ser_bus.ser_ready = 1'b0;
        send_block(BLK_A);
        send_block(BLK_B);
        checks++;
        if (ovf !== 1'b0 || blk_level !== 2'd2) begin
            errors++;
            $display("[TB] FAIL ovf_before: ovf=%b level=%0d need 0 2", ovf, blk_level);
        end
        send_block(BLK_C);
        checks++;
        if (ovf !== 1'b1 || blk_level !== 2'd2 || ser_bus.ser_data !== exp_word(BLK_A, 0)) begin
            errors++;
            $display("[TB] FAIL ovf_set: ovf=%b level=%0d data=%h need 1 2 %h",
                     ovf, blk_level, ser_bus.ser_data, exp_word(BLK_A, 0));
        end
        ser_bus.ser_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            blk = (i < 4) ? BLK_A : BLK_B;
            checks++;
            if (ser_bus.ser_valid !== 1'b1 || ser_bus.ser_data !== exp_word(blk, i % 4)
                || ser_bus.ser_last !== ((i % 4) == 3)) begin
                errors++;
                $display("[TB] FAIL ovf_drain%0d: valid=%b data=%h last=%b need 1 %h %b", i,
                         ser_bus.ser_valid, ser_bus.ser_data, ser_bus.ser_last,
                         exp_word(blk, i % 4), ((i % 4) == 3));
            end
            tick();
        end
        checks++;
        if (ser_bus.ser_valid !== 1'b0 || blk_level !== 2'd0 || ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_empty: valid=%b level=%0d ovf=%b need 0 0 1",
                     ser_bus.ser_valid, blk_level, ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_clear: got %b need 0", ovf);
        end
    endtask

    task automatic test_full_boundary();
        logic [127:0] blk;
        ser_bus.ser_ready = 1'b0;
        send_block(BLK_A);
        send_block(BLK_B);
        ser_bus.ser_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (ser_bus.ser_last !== 1'b1 || ser_bus.ser_data !== exp_word(BLK_A, 3)
            || blk_level !== 2'd2) begin
            errors++;
            $display("[TB] FAIL full_pre: last=%b data=%h level=%0d need 1 %h 2",
                     ser_bus.ser_last, ser_bus.ser_data, blk_level, exp_word(BLK_A, 3));
        end
        aes_data  = BLK_C;
        aes_valid = 1'b1;
        tick();
        aes_valid = 1'b0;
        checks++;
        if (blk_level !== 2'd2 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_coincide: level=%0d ovf=%b need 2 0", blk_level, ovf);
        end
        for (int i = 0; i < 8; i++) begin
            blk = (i < 4) ? BLK_B : BLK_C;
            checks++;
            if (ser_bus.ser_valid !== 1'b1 || ser_bus.ser_data !== exp_word(blk, i % 4)) begin
                errors++;
                $display("[TB] FAIL full_drain%0d: valid=%b data=%h need 1 %h", i,
                         ser_bus.ser_valid, ser_bus.ser_data, exp_word(blk, i % 4));
            end
            tick();
        end
        checks++;
        if (blk_level !== 2'd0 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_end: level=%0d ovf=%b need 0 0", blk_level, ovf);
        end
    endtask

    task automatic test_reset_mid_stream();
        ser_bus.ser_ready = 1'b1;
        aes_data  = BLK_D;
        aes_valid = 1'b1;
        tick();
        aes_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (ser_bus.ser_data !== exp_word(BLK_D, 2)) begin
            errors++;
            $display("[TB] FAIL mid_pre: data=%h need %h", ser_bus.ser_data, exp_word(BLK_D, 2));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ser_bus.ser_valid !== 1'b0 || ser_bus.ser_data !== 32'h0 || ser_bus.ser_last !== 1'b0
            || blk_level !== 2'd0) begin
            errors++;
            $display("[TB] FAIL mid_async: valid=%b data=%h last=%b level=%0d need 0 0 0 0",
                     ser_bus.ser_valid, ser_bus.ser_data, ser_bus.ser_last, blk_level);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ser_bus.ser_valid !== 1'b0 || blk_level !== 2'd0) begin
                errors++;
                $display("[TB] FAIL mid_release%0d: valid=%b level=%0d need 0 0",
                         i, ser_bus.ser_valid, blk_level);
            end
        end
    endtask

    task automatic test_valid_across_reset();
        ser_bus.ser_ready = 1'b1;
        rst_n     = 1'b0;
        aes_data  = BLK_E;
        aes_valid = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (blk_level !== 2'd1 || ser_bus.ser_data !== exp_word(BLK_E, 0)) begin
            errors++;
            $display("[TB] FAIL held_capture: level=%0d data=%h need 1 %h",
                     blk_level, ser_bus.ser_data, exp_word(BLK_E, 0));
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (blk_level !== 2'd0 || ser_bus.ser_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_once: level=%0d valid=%b need 0 0",
                     blk_level, ser_bus.ser_valid);
        end
        aes_valid = 1'b0;
        tick();
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst_n             = 1'b0;
        aes_data          = '0;
        aes_valid         = 1'b0;
        ovf_clr           = 1'b0;
        ser_bus.ser_ready = 1'b0;
        test_reset();
        test_single_block();
        test_level_valid();
        test_stall();
        test_overflow();
        test_full_boundary();
        test_reset_mid_stream();
        test_valid_across_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
